// File: rtl/router_pkg.sv
// Shared router types: injection packet format and injection-arbiter defaults.
package router_pkg;

    localparam int N_INJ_REQ = 4;
    localparam int INJ_CNT_W = 16;

    typedef logic [INJ_CNT_W-1:0] inj_cnt_t;

    typedef struct packed {
        logic [3:0]  dst;
        logic [3:0]  src;
        logic [23:0] data;
    } pkt_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority picker: search starts just above ptr.
module rr_arbiter
    import router_pkg::*;
#(
    parameter int N_REQ = N_INJ_REQ
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [N_REQ-1:0]         grant
);

    localparam int PW = $clog2(N_REQ);

    logic           found;
    logic [PW-1:0]  sel;

    always_comb begin
        grant = '0;
        found = 1'b0;
        sel   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            sel = PW'((int'(ptr) + k) % N_REQ);
            if (!found && req[sel]) begin
                grant[sel] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/inj_arbiter.sv
// Local injection arbiter: round-robin over requesters into one registered
// output entry, with per-requester accepted-packet counters.
module inj_arbiter
    import router_pkg::*;
#(
    parameter int N_REQ = N_INJ_REQ,
    parameter int CNT_W = $bits(inj_cnt_t)
) (
    input  logic                        clk,
    input  logic                        arst_n,
    input  logic [N_REQ-1:0]            req_valid,
    input  pkt_t [N_REQ-1:0]            req_pkt,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [N_REQ-1:0]            req_en,
    output logic                        out_valid,
    output pkt_t                        out_pkt,
    input  logic                        out_ready,
    input  logic                        cnt_clr,
    output logic [N_REQ-1:0][CNT_W-1:0] grant_cnt
);

    localparam int PW = $clog2(N_REQ);

    logic [PW-1:0]    last_grant;
    logic [PW-1:0]    win_idx;
    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] grant;
    logic             load_en;
    logic             accept;

    assign eligible = req_valid & req_en;
    assign load_en  = !out_valid || out_ready;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr (
        .req   (eligible),
        .ptr   (last_grant),
        .grant (grant)
    );

    // Gate with arst_n so nothing is offered while reset is held.
    assign req_ready = (arst_n && load_en) ? grant : '0;
    assign accept    = |req_ready;

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) win_idx = PW'(i);
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            out_valid  <= 1'b0;
            out_pkt    <= '0;
            last_grant <= PW'(N_REQ - 1);
        end else begin
            if (load_en) out_valid <= accept;
            if (accept) begin
                out_pkt    <= req_pkt[win_idx];
                last_grant <= win_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            grant_cnt <= '0;
        end else if (cnt_clr) begin
            grant_cnt <= '0;
        end else if (accept) begin
            grant_cnt[win_idx] <= grant_cnt[win_idx] + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_inj_arbiter.sv
// Directed table-driven bench for inj_arbiter plus reset corner sequences.
module tb_inj_arbiter;
    import router_pkg::*;

    localparam int N  = 4;
    localparam int CW = 4;

    logic                  clk = 1'b0;
    logic                  arst_n;
    logic [N-1:0]          req_valid;
    pkt_t [N-1:0]          req_pkt;
    logic [N-1:0]          req_ready;
    logic [N-1:0]          req_en;
    logic                  out_valid;
    pkt_t                  out_pkt;
    logic                  out_ready;
    logic                  cnt_clr;
    logic [N-1:0][CW-1:0]  grant_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [3:0] valid;
        logic [3:0] en;
        logic       ord;
        logic       clr;
        logic [3:0] rdy;
        logic       ov;
        logic [3:0] src;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    inj_arbiter #(
        .N_REQ (N),
        .CNT_W (CW)
    ) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .req_valid (req_valid),
        .req_pkt   (req_pkt),
        .req_ready (req_ready),
        .req_en    (req_en),
        .out_valid (out_valid),
        .out_pkt   (out_pkt),
        .out_ready (out_ready),
        .cnt_clr   (cnt_clr),
        .grant_cnt (grant_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input int n, input logic [3:0] v, input logic [3:0] e,
                       input logic o, input logic c, input logic [3:0] r,
                       input logic ov, input logic [3:0] s);
        vec_t t;
        t.valid = v; t.en = e; t.ord = o; t.clr = c;
        t.rdy = r; t.ov = ov; t.src = s;
        for (int k = 0; k < n; k++) vecs.push_back(t);
    endtask

    task automatic run(input int lo, input int hi, input string tag);
        for (int i = lo; i < hi; i++) begin
            req_valid = vecs[i].valid;
            req_en    = vecs[i].en;
            out_ready = vecs[i].ord;
            cnt_clr   = vecs[i].clr;
            #1;
            chk($sformatf("%s[%0d] req_ready", tag, i), 32'(req_ready), 32'(vecs[i].rdy));
            @(posedge clk);
            #1;
            chk($sformatf("%s[%0d] out_valid", tag, i), 32'(out_valid), 32'(vecs[i].ov));
            if (vecs[i].ov)
                chk($sformatf("%s[%0d] out_src", tag, i), 32'(out_pkt.src), 32'(vecs[i].src));
        end
        cnt_clr = 1'b0;
    endtask

    task automatic chk_cnt(input string tag, input int c0, input int c1,
                           input int c2, input int c3);
        chk({tag, " cnt0"}, 32'(grant_cnt[0]), 32'(c0));
        chk({tag, " cnt1"}, 32'(grant_cnt[1]), 32'(c1));
        chk({tag, " cnt2"}, 32'(grant_cnt[2]), 32'(c2));
        chk({tag, " cnt3"}, 32'(grant_cnt[3]), 32'(c3));
    endtask

    initial begin
        int b0, b1, b2, b3, b4, b5, b6, b7;

        for (int i = 0; i < N; i++) begin
            req_pkt[i].dst  = 4'(i + 1);
            req_pkt[i].src  = 4'(i);
            req_pkt[i].data = 24'hA00 + 24'(i);
        end

        b0 = vecs.size();
        for (int k = 0; k < 2; k++) begin
            add(1, 4'hF, 4'hF, 1, 0, 4'b0001, 1, 4'd0);
            add(1, 4'hF, 4'hF, 1, 0, 4'b0010, 1, 4'd1);
            add(1, 4'hF, 4'hF, 1, 0, 4'b0100, 1, 4'd2);
            add(1, 4'hF, 4'hF, 1, 0, 4'b1000, 1, 4'd3);
        end
        b1 = vecs.size();
        add(5, 4'hF, 4'hF, 0, 0, 4'b0000, 1, 4'd3);
        add(1, 4'hF, 4'hF, 1, 0, 4'b0001, 1, 4'd0);
        b2 = vecs.size();
        add(1, 4'h0, 4'hF, 1, 1, 4'b0000, 0, 4'd0);
        for (int k = 0; k < 2; k++) begin
            add(1, 4'hF, 4'hA, 1, 0, 4'b0010, 1, 4'd1);
            add(1, 4'hF, 4'hA, 1, 0, 4'b1000, 1, 4'd3);
        end
        b3 = vecs.size();
        add(1, 4'h0, 4'hF, 1, 1, 4'b0000, 0, 4'd0);
        add(10, 4'h4, 4'hF, 1, 0, 4'b0100, 1, 4'd2);
        b4 = vecs.size();
        add(1, 4'hF, 4'h0, 1, 0, 4'b0000, 0, 4'd0);
        add(1, 4'hF, 4'h1, 1, 0, 4'b0001, 1, 4'd0);
        b5 = vecs.size();
        add(1, 4'h0, 4'hF, 1, 1, 4'b0000, 0, 4'd0);
        add(17, 4'h1, 4'hF, 1, 0, 4'b0001, 1, 4'd0);
        b6 = vecs.size();
        add(1, 4'h1, 4'hF, 1, 1, 4'b0001, 1, 4'd0);
        b7 = vecs.size();

        arst_n    = 1'b0;
        req_valid = 4'hF;
        req_en    = 4'hF;
        out_ready = 1'b1;
        cnt_clr   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_pkt", 32'(out_pkt), 32'd0);
        chk("rst req_ready", 32'(req_ready), 32'd0);
        chk_cnt("rst", 0, 0, 0, 0);
        @(negedge clk);
        arst_n = 1'b1;

        run(b0, b1, "rr");
        chk_cnt("rr", 2, 2, 2, 2);
        run(b1, b2, "stall");
        run(b2, b3, "mask");
        chk_cnt("mask", 0, 2, 0, 2);
        run(b3, b4, "single");
        chk_cnt("single", 0, 0, 10, 0);
        run(b4, b5, "en_chg");
        run(b5, b6, "wrap");
        chk_cnt("wrap", 1, 0, 0, 0);
        run(b6, b7, "clr_acc");
        chk_cnt("clr_acc", 0, 0, 0, 0);

        req_valid = 4'hF;
        req_en    = 4'hF;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("mid out_valid", 32'(out_valid), 32'd1);
        chk("mid out_src", 32'(out_pkt.src), 32'd1);
        #2;
        arst_n = 1'b0;
        #1;
        chk("async out_valid", 32'(out_valid), 32'd0);
        chk("async out_pkt", 32'(out_pkt), 32'd0);
        chk("async req_ready", 32'(req_ready), 32'd0);
        chk_cnt("async", 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("held out_valid", 32'(out_valid), 32'd0);
        chk("held req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        arst_n = 1'b1;
        #1;
        chk("post req_ready", 32'(req_ready), 32'b0001);
        @(posedge clk);
        #1;
        chk("post out_valid", 32'(out_valid), 32'd1);
        chk("post out_src", 32'(out_pkt.src), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/inj_arbiter.md
INJ_ARBITER -- requirements
Module: inj_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of packet requesters sharing one local injection port (range 2..8).
REQ-002 Parameter CNT_W, default 16, width of each per-requester grant counter.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 arst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  N_REQ  per-requester packet-available flag.
REQ-006 req_pkt  input  N_REQ x pkt_t  per-requester packet, stable while req_valid high and not accepted.
REQ-007 req_ready  output  N_REQ  per-requester accept; one-hot or zero.
REQ-008 req_en  input  N_REQ  configuration mask; 0 excludes the requester from arbitration.
REQ-009 out_valid  output  1  injection packet present.
REQ-010 out_pkt  output  pkt_t  injection packet to router local port.
REQ-011 out_ready  input  1  router local port accepts out_pkt.
REQ-012 cnt_clr  input  1  synchronous clear of all grant counters.
REQ-013 grant_cnt  output  N_REQ x CNT_W  accepted-packet count per requester.

Function
REQ-014 Accept on a port = valid and ready both high at posedge clk; packets are never dropped or duplicated.
REQ-015 Output stage is one registered entry (out_valid, out_pkt); load_en = !out_valid || out_ready.
REQ-016 Eligible set = req_valid & req_en; winner = first eligible index found searching upward from (last_grant+1) mod N_REQ, wrapping.
REQ-017 req_ready[i] is high only when load_en is high, eligible is non-zero, and i is the winner; combinational from req_valid, req_en, out_valid, out_ready.
REQ-018 On accept from requester i, out_pkt <= req_pkt[i], out_valid <= 1, last_grant <= i, all in the same edge.
REQ-019 If out_ready is high with out_valid high and no eligible requester, out_valid <= 0 at that edge.
REQ-020 Latency 1 cycle from requester accept to out_valid; sustained throughput 1 packet/cycle with out_ready held high.
REQ-021 last_grant is unchanged in cycles without an accept, including out_ready stalls.
REQ-022 While out_valid is high and out_ready is low, out_pkt and out_valid hold and every req_ready is 0.
REQ-023 A req_en bit may change on any cycle; it takes effect the same cycle and never affects a packet already in the output stage.
REQ-024 grant_cnt[i] increments by 1 on each accept from requester i; it wraps from 2^CNT_W-1 to 0.
REQ-025 cnt_clr zeroes all counters; an accept in the same cycle is discarded (counter reads 0).
REQ-026 With exactly one eligible requester the block streams it back-to-back without bubbles.

Reset
REQ-027 arst_n low asynchronously sets out_valid=0, out_pkt='0, last_grant=N_REQ-1 (first winner search starts at index 0), all grant_cnt=0.
REQ-028 req_ready is 0 throughout reset; a packet in the output stage at reset assertion is discarded.
REQ-029 After arst_n deasserts, the first accept may occur at the first posedge clk.

Structure
REQ-030 pkt_t stays in router_pkg; router_pkg also gets the N_INJ_REQ default constant and the inj_cnt_t typedef (CNT_W bits).
REQ-031 Rotating-priority selection is a combinational sub-module rr_arbiter (request, pointer -> one-hot grant); inj_arbiter owns all registers.

Verification
REQ-032 Reset, then all four requesters valid and enabled, out_ready=1 -> accepts in order 0,1,2,3,0,...; each grant_cnt=2 after 8 cycles.
REQ-033 Only req 2 valid, out_ready=1 for 10 cycles -> 10 consecutive out_pkt from req 2, no bubbles, grant_cnt[2]=10.
REQ-034 out_ready=0 for 5 cycles with all requesters valid -> out_pkt frozen, req_ready=0; after release, next winner = last_grant+1.
REQ-035 req_en=4'b1010 with all requesters valid -> only 1 and 3 alternate; grant_cnt[0] and grant_cnt[2] stay 0.
REQ-036 CNT_W=4, 17 accepts from req 0 -> grant_cnt[0]=1 (wrap); cnt_clr coincident with an accept -> 0.
REQ-037 arst_n asserted mid-stream with out_valid=1 -> out_valid=0 immediately; after release the first grant goes to req 0.
